data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the multicycle RISC-V core: the memory end of the core's dAddress/dWriteData/MemRead/MemWrite/dReadData interface.
- Serves word reads and writes from an internal RAM with a programmable fixed latency.
- Adds a one-cycle completion pulse and error flagging for misaligned, out-of-range and conflicting requests.
- Replaces the constant dReadData stimulus currently driven into the core.

Parameters:
- ADDR_WIDTH, 10, byte-address bits decoded; RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- MemRead  input  1  read strobe from core.
- MemWrite  input  1  write strobe from core.
- dAddress  input  32  byte address.
- dWriteData  input  32  store data.
- dReadData  output  32  registered read data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_error  output  1  one-cycle error pulse, coincident with mem_ready.
- busy  output  1  high while an access is in flight.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, strobe-history register 0, dReadData=0, mem_ready=0, mem_error=0, busy=0.
  - RAM contents are not cleared by reset.
  - Reset mid-access aborts the access. A pending write is discarded if reset arrives before its commit edge.
- Request detection is edge-triggered. req = MemRead|MemWrite. A request starts on the first rising edge where req=1 and the registered previous req=0.
  - A strobe held high across many cycles is one request.
  - The previous-req register updates every cycle in every state.
- States:
  - IDLE: on a new request, capture dAddress, dWriteData and op (read/write/conflict), load cnt=LATENCY-1, go to WAIT, busy=1.
  - WAIT: if cnt!=0, decrement. If cnt==0, perform the access at this edge, go to RESP.
  - RESP: mem_ready=1 (and mem_error if flagged) for exactly this cycle, busy=0. Next edge goes to IDLE.
- Timing: request accepted at edge k; access performed at edge k+LATENCY; mem_ready high during the cycle following edge k+LATENCY.
- Strobe edges that arrive while in WAIT or RESP are ignored and not queued. The core must hold off until mem_ready.
- Word index = captured address[ADDR_WIDTH-1:2].
- Error conditions, each producing mem_error=1 with mem_ready:
  - Misaligned: address[1:0]!=0.
  - Out-of-range: any of address[31:ADDR_WIDTH] nonzero.
  - Conflict: MemRead and MemWrite both high at acceptance.
  - On error: no RAM write, dReadData loaded with 0.
- Read: dReadData updated at the access edge and held until the next completed read or error. Writes leave dReadData unchanged.
- Write: the RAM word is updated at the access edge. A read issued later returns the new data.

Test Plan:
- Reset with rst=0 for 2 cycles while MemRead=1 -> all outputs 0, busy=0. After release with the strobe still high, no access (no edge).
- LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each mem_ready pulses exactly 1 cycle, 2 cycles after the accepting edge. dReadData=0xDEADBEEF; mem_error=0.
- Read 0x12 (misaligned) and 0x400 (out of range at ADDR_WIDTH=10) -> mem_ready and mem_error both pulse, dReadData=0. A follow-up read of 0x10 still returns 0xDEADBEEF.
- MemRead and MemWrite rise together with dWriteData=0x1 at 0x20 -> mem_error pulse. A later read of 0x20 returns its prior value (0 if never written).
- MemWrite held high 6 cycles at 0x24 with 0x55 -> exactly one mem_ready. A second MemRead pulse during WAIT is ignored (no extra mem_ready).
- Write 0x77 to 0x28, assert rst=0 one cycle after acceptance (before commit) -> busy drops immediately. A later read of 0x28 returns the old value. Repeat with LATENCY=1 -> mem_ready one cycle after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory end of the multicycle RISC-V core's data port. It serves 32-bit
//   word reads and writes from an internal RAM after a fixed, programmable
//   latency. Each access ends with a one-cycle completion pulse. Misaligned,
//   out-of-range and read+write conflicting requests also raise an error pulse.
//
// Parameters
//   ADDR_WIDTH  byte-address bits decoded; RAM holds 2^(ADDR_WIDTH-2) words
//   LATENCY     cycles from request acceptance to access edge (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   MemRead     read strobe from core
//   MemWrite    write strobe from core
//   dAddress    byte address
//   dWriteData  store data
//   dReadData   registered read data (0 after an error)
//   mem_ready   one-cycle completion pulse
//   mem_error   one-cycle error pulse, coincident with mem_ready
//   busy        high while an access is in flight
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        busy
);

  localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    prev_req_q;
  logic                    armed_q;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [ADDR_WIDTH-3:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [31:0]             ram [WORDS];

  logic req;
  logic new_req;
  logic misaligned;
  logic out_of_range;
  logic conflict;
  logic access;
  logic ram_we;

  assign req          = MemRead | MemWrite;
  // The first edge after reset only samples the strobe. A strobe held high
  // through reset is therefore not taken as a fresh request.
  assign new_req      = req & ~prev_req_q & armed_q;
  assign misaligned   = |dAddress[1:0];
  assign out_of_range = |dAddress[31:ADDR_WIDTH];
  assign conflict     = MemRead & MemWrite;
  assign access       = (state_q == WAIT) && (cnt_q == 4'd0);
  // No write path is open while in reset: reset forces IDLE.
  assign ram_we       = access & wr_q & ~err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (new_req) begin
          idx_d   = dAddress[ADDR_WIDTH-1:2];
          wdata_d = dWriteData;
          wr_d    = MemWrite & ~MemRead;
          err_d   = misaligned | out_of_range | conflict;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (err_q) begin
            rdata_d = 32'd0;
          end else if (!wr_q) begin
            rdata_d = ram[idx_q];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      prev_req_q <= 1'b0;
      armed_q    <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_req_q <= req;
      armed_q    <= 1'b1;
      wr_q       <= wr_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Captured address/data need no reset: they are only consumed after a
  // fresh capture in IDLE.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx_q] <= wdata_q;
    end
  end

  assign dReadData = rdata_q;
  assign mem_ready = (state_q == RESP);
  assign mem_error = (state_q == RESP) & err_q;
  assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;

  logic [31:0] dReadData,  dReadData2;
  logic        mem_ready,  mem_ready2;
  logic        mem_error,  mem_error2;
  logic        busy,       busy2;

  int vectors;
  int miscompares;

  // Both instances see identical stimulus; u_dut2 runs with LATENCY=1.
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData), .dReadData(dReadData),
    .mem_ready(mem_ready), .mem_error(mem_error), .busy(busy)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut2 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData), .dReadData(dReadData2),
    .mem_ready(mem_ready2), .mem_error(mem_error2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe high for exactly one rising edge; returns at the falling edge
  // just after the accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    MemRead    = rd;
    MemWrite   = wr;
    dAddress   = a;
    dWriteData = d;
    @(negedge clk);
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
  endtask

  // Counts falling edges until the selected instance shows mem_ready (bounded).
  task automatic wait_ready(input bit which, output int lat);
    lat = 0;
    while (((which == 1'b0) ? !mem_ready : !mem_ready2) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int rdy_cnt;
    int busy_cnt;
    rst = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
    dAddress = 32'h10; dWriteData = 32'h0;
    repeat (2) @(negedge clk);
    vectors++;
    if (dReadData !== 32'd0 || mem_ready !== 1'b0 || mem_error !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdata=%h rdy=%b err=%b busy=%b, want 0/0/0/0",
               dReadData, mem_ready, mem_error, busy);
    end
    vectors++;
    if (busy2 !== 1'b0 || mem_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_lat1: busy=%b rdy=%b, want 0/0", busy2, mem_ready2);
    end
    rst = 1'b1;
    rdy_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready || mem_ready2) rdy_cnt++;
      if (busy || busy2) busy_cnt++;
    end
    vectors++;
    if (rdy_cnt != 0 || busy_cnt != 0) begin
      miscompares++;
      $display("FAIL held_through_reset: ready_cycles=%0d busy_cycles=%0d, want 0/0",
               rdy_cnt, busy_cnt);
    end
    MemRead = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL write_busy: got %b want 1", busy);
    end
    wait_ready(1'b0, lat);
    vectors++;
    if (lat != 2 || mem_error !== 1'b0) begin
      miscompares++;
      $display("FAIL write_latency: lat=%0d err=%b, want 2/0", lat, mem_error);
    end
    @(negedge clk);
    vectors++;
    if (mem_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_pulse_width: rdy=%b busy=%b, want 0/0", mem_ready, busy);
    end
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready(1'b0, lat);
    vectors++;
    if (lat != 2 || dReadData !== 32'hDEADBEEF || mem_error !== 1'b0) begin
      miscompares++;
      $display("FAIL read_back: lat=%0d rdata=%h err=%b, want 2/deadbeef/0",
               lat, dReadData, mem_error);
    end
    @(negedge clk);
    vectors++;
    if (mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL read_pulse_width: rdy=%b want 0", mem_ready);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic        wrs   [4];
    int lat;
    addrs[0] = 32'h12;  wrs[0] = 1'b0;
    addrs[1] = 32'h400; wrs[1] = 1'b0;
    addrs[2] = 32'h12;  wrs[2] = 1'b1;
    addrs[3] = 32'h410; wrs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(~wrs[i], wrs[i], addrs[i], 32'h12345678);
      wait_ready(1'b0, lat);
      vectors++;
      if (lat != 2 || mem_error !== 1'b1 || dReadData !== 32'd0) begin
        miscompares++;
        $display("FAIL error_%0d addr=%h: lat=%0d err=%b rdata=%h, want 2/1/00000000",
                 i, addrs[i], lat, mem_error, dReadData);
      end
      @(negedge clk);
      vectors++;
      if (mem_error !== 1'b0 || mem_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL error_pulse_%0d: rdy=%b err=%b, want 0/0", i, mem_ready, mem_error);
      end
    end
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready(1'b0, lat);
    vectors++;
    if (dReadData !== 32'hDEADBEEF || mem_error !== 1'b0) begin
      miscompares++;
      $display("FAIL after_errors_read: rdata=%h err=%b, want deadbeef/0", dReadData, mem_error);
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    int lat;
    issue(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    wait_ready(1'b0, lat);
    @(negedge clk);
    issue(1'b1, 1'b1, 32'h20, 32'h1);
    wait_ready(1'b0, lat);
    vectors++;
    if (mem_error !== 1'b1 || dReadData !== 32'd0) begin
      miscompares++;
      $display("FAIL conflict: err=%b rdata=%h, want 1/00000000", mem_error, dReadData);
    end
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    wait_ready(1'b0, lat);
    vectors++;
    if (dReadData !== 32'hA5A5A5A5 || mem_error !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_no_write: rdata=%h err=%b, want a5a5a5a5/0", dReadData, mem_error);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c1, c2, lat;
    @(negedge clk);
    MemWrite = 1'b1; dAddress = 32'h24; dWriteData = 32'h55;
    c1 = 0; c2 = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_ready)  c1++;
      if (mem_ready2) c2++;
      if (i == 6) MemWrite = 1'b0;
    end
    vectors++;
    if (c1 != 1 || c2 != 1) begin
      miscompares++;
      $display("FAIL held_write_pulses: lat2=%0d lat1=%0d, want 1/1", c1, c2);
    end
    vectors++;
    if (dReadData !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL write_keeps_rdata: got %h want a5a5a5a5", dReadData);
    end
    issue(1'b1, 1'b0, 32'h24, 32'h0);
    c1 = 0; c2 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_ready)  c1++;
      if (mem_ready2) c2++;
      if (i == 1) MemRead = 1'b1;
      if (i == 2) MemRead = 1'b0;
    end
    vectors++;
    if (c1 != 1 || c2 != 1 || dReadData !== 32'h55) begin
      miscompares++;
      $display("FAIL pulse_in_wait: pulses=%0d/%0d rdata=%h, want 1/1/00000055",
               c1, c2, dReadData);
    end
    lat = 0;
  endtask

  task automatic test_abort();
    int lat;
    issue(1'b0, 1'b1, 32'h28, 32'h11);
    wait_ready(1'b0, lat);
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h28, 32'h77);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_before: got %b want 1", busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || busy2 !== 1'b0 || mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy_drop: busy=%b busy_lat1=%b rdy=%b, want 0/0/0",
               busy, busy2, mem_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h28, 32'h0);
    wait_ready(1'b0, lat);
    vectors++;
    if (lat != 2 || dReadData !== 32'h11 || dReadData2 !== 32'h11) begin
      miscompares++;
      $display("FAIL abort_old_value: lat=%0d rdata=%h rdata_lat1=%h, want 2/00000011/00000011",
               lat, dReadData, dReadData2);
    end
    @(negedge clk);
  endtask

  task automatic test_latency1();
    int lat;
    issue(1'b1, 1'b0, 32'h24, 32'h0);
    wait_ready(1'b1, lat);
    vectors++;
    if (lat != 1 || dReadData2 !== 32'h55 || mem_error2 !== 1'b0) begin
      miscompares++;
      $display("FAIL lat1_read: lat=%0d rdata=%h err=%b, want 1/00000055/0",
               lat, dReadData2, mem_error2);
    end
    @(negedge clk);
    vectors++;
    if (mem_ready2 !== 1'b0 || mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lat1_vs_lat2: rdy_lat1=%b rdy_lat2=%b, want 0/1", mem_ready2, mem_ready);
    end
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h2C, 32'h99);
    wait_ready(1'b1, lat);
    vectors++;
    if (lat != 1 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL lat1_write: lat=%0d busy=%b, want 1/0", lat, busy2);
    end
    repeat (2) @(negedge clk);
    issue(1'b1, 1'b0, 32'h2C, 32'h0);
    wait_ready(1'b1, lat);
    vectors++;
    if (dReadData2 !== 32'h99) begin
      miscompares++;
      $display("FAIL lat1_readback: got %h want 00000099", dReadData2);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    dAddress    = 32'h0;
    dWriteData  = 32'h0;
    test_reset();
    test_write_read();
    test_errors();
    test_conflict();
    test_back_to_back();
    test_abort();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
